// File: rtl/pc_gen.sv
// pc_gen: program-counter generator with stall, branch/jump, return-address stack and exception entry/return
module pc_gen #(
  parameter int WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(32'h00003000),
  parameter logic [WIDTH-1:0] EXC_VECTOR = WIDTH'(32'h00004180),
  parameter int STEP = 4,
  parameter int RAS_DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stall,
  input  logic             i_br_taken,
  input  logic [WIDTH-1:0] i_br_target,
  input  logic             i_jump,
  input  logic [WIDTH-1:0] i_jump_target,
  input  logic             i_call,
  input  logic             i_ret,
  input  logic             i_exc,
  input  logic             i_eret,
  output logic [WIDTH-1:0] o_pc,
  output logic [WIDTH-1:0] o_epc,
  output logic             o_in_handler,
  output logic             o_ras_empty,
  output logic             o_ras_full,
  output logic             o_ras_underflow
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [WIDTH-1:0] MASK = ~WIDTH'(STEP - 1);
  typedef enum logic {NORMAL, HANDLER} state_t;
  state_t r_state, w_state_nx;
  logic [WIDTH-1:0] r_pc, r_epc, w_pc_nx, w_epc_nx, w_seq, w_tgt, w_top;
  logic [WIDTH-1:0] r_ras [RAS_DEPTH];
  logic [PW-1:0] r_ptr, w_ptr_nx;
  logic [PW:0] r_cnt, w_cnt_nx;
  logic r_uflow, w_uflow, w_push;
  assign w_seq = r_pc + WIDTH'(STEP);
  assign w_tgt = (i_jump ? i_jump_target : i_br_target) & MASK;
  // r_ptr points at the next free slot, so the top of stack sits one below it
  assign w_top = r_ras[r_ptr - PW'(1)];
  assign o_pc = r_pc;
  assign o_epc = r_epc;
  assign o_in_handler = (r_state == HANDLER);
  assign o_ras_empty = (r_cnt == '0);
  assign o_ras_full = (r_cnt == (PW+1)'(RAS_DEPTH));
  assign o_ras_underflow = r_uflow;
  // next-pc selection in priority order: exc, stall, eret, jump, branch, ret, sequential
  always_comb begin
    w_state_nx = r_state;
    w_pc_nx = r_pc;
    w_epc_nx = r_epc;
    w_ptr_nx = r_ptr;
    w_cnt_nx = r_cnt;
    w_push = 1'b0;
    w_uflow = 1'b0;
    if (i_exc) begin
      w_pc_nx = EXC_VECTOR;
      w_state_nx = HANDLER;
      w_epc_nx = (r_state == NORMAL) ? r_pc : r_epc;
    end else if (!i_stall) begin
      if (i_eret && r_state == HANDLER) begin
        w_pc_nx = r_epc;
        w_state_nx = NORMAL;
      end else if (i_jump || i_br_taken) begin
        w_pc_nx = w_tgt;
        w_push = i_call;
        w_ptr_nx = i_call ? r_ptr + PW'(1) : r_ptr;
        w_cnt_nx = (i_call && !o_ras_full) ? r_cnt + (PW+1)'(1) : r_cnt;
      end else if (i_ret) begin
        w_pc_nx = o_ras_empty ? w_seq : w_top;
        w_uflow = o_ras_empty;
        w_ptr_nx = o_ras_empty ? r_ptr : r_ptr - PW'(1);
        w_cnt_nx = o_ras_empty ? r_cnt : r_cnt - (PW+1)'(1);
      end else begin
        w_pc_nx = w_seq;
      end
    end
  end
  // handler-state register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= NORMAL;
    else r_state <= w_state_nx;
  end
  // pc, epc, stack pointer/count and underflow pulse
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_pc <= RESET_VECTOR;
      r_epc <= '0;
      r_ptr <= '0;
      r_cnt <= '0;
      r_uflow <= 1'b0;
    end else begin
      r_pc <= w_pc_nx;
      r_epc <= w_epc_nx;
      r_ptr <= w_ptr_nx;
      r_cnt <= w_cnt_nx;
      r_uflow <= w_uflow;
    end
  end
  // circular return-address storage; a push when full overwrites the oldest entry
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < RAS_DEPTH; i++) r_ras[i] <= '0;
    end else if (w_push) begin
      r_ras[r_ptr] <= w_seq;
    end
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed and random stimulus against a queue-based reference of the pc generator
module tb_pc_gen;
  localparam logic [31:0] RV = 32'h0000_3000;
  localparam logic [31:0] EV = 32'h0000_4180;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic st = 0, br = 0, jp = 0, cl = 0, rt = 0, ex = 0, er = 0;
  logic [31:0] bt = 0, jt = 0;
  logic [31:0] pc, epc;
  logic in_h, r_empty, r_full, r_uf;
  int n_chk = 0, n_fail = 0;
  logic [31:0] m_pc, m_epc;
  logic m_h, m_uf;
  logic [31:0] m_q[$];
  always #5 clk = ~clk;
  pc_gen #(.WIDTH(32), .RESET_VECTOR(RV), .EXC_VECTOR(EV), .STEP(4), .RAS_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_stall(st), .i_br_taken(br), .i_br_target(bt),
    .i_jump(jp), .i_jump_target(jt), .i_call(cl), .i_ret(rt), .i_exc(ex), .i_eret(er),
    .o_pc(pc), .o_epc(epc), .o_in_handler(in_h), .o_ras_empty(r_empty),
    .o_ras_full(r_full), .o_ras_underflow(r_uf)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic m_reset();
    m_pc = RV;
    m_epc = 0;
    m_h = 0;
    m_uf = 0;
    m_q.delete();
  endtask
  task automatic m_step();
    logic [31:0] t;
    m_uf = 0;
    if (ex) begin
      if (!m_h) m_epc = m_pc;
      m_h = 1;
      m_pc = EV;
    end else if (st) begin
    end else if (er && m_h) begin
      m_pc = m_epc;
      m_h = 0;
    end else if (jp || br) begin
      t = (jp ? jt : bt) & ~32'h3;
      if (cl) begin
        m_q.push_back(m_pc + 4);
        if (m_q.size() > 4) void'(m_q.pop_front());
      end
      m_pc = t;
    end else if (rt) begin
      if (m_q.size() > 0) m_pc = m_q.pop_back();
      else begin
        m_pc = m_pc + 4;
        m_uf = 1;
      end
    end else begin
      m_pc = m_pc + 4;
    end
  endtask
  task automatic cmp_all(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".epc"}, epc, m_epc);
    check({tag, ".in_handler"}, {31'b0, in_h}, {31'b0, m_h});
    check({tag, ".ras_empty"}, {31'b0, r_empty}, {31'b0, m_q.size() == 0});
    check({tag, ".ras_full"}, {31'b0, r_full}, {31'b0, m_q.size() == 4});
    check({tag, ".ras_underflow"}, {31'b0, r_uf}, {31'b0, m_uf});
  endtask
  task automatic drive(input string tag, input logic a_st, input logic a_br, input logic [31:0] a_bt,
                       input logic a_jp, input logic [31:0] a_jt, input logic a_cl, input logic a_rt,
                       input logic a_ex, input logic a_er);
    @(negedge clk);
    st = a_st; br = a_br; bt = a_bt; jp = a_jp; jt = a_jt; cl = a_cl; rt = a_rt; ex = a_ex; er = a_er;
    m_step();
    @(posedge clk);
    #1;
    cmp_all(tag);
  endtask
  task automatic idle(input string tag);
    drive(tag, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic do_reset();
    @(negedge clk);
    st = 0; br = 0; bt = 0; jp = 0; jt = 0; cl = 0; rt = 0; ex = 0; er = 0;
    #2;
    rst_n = 1'b0;
    m_reset();
    #1;
    check("rst_async.pc", pc, RV);
    cmp_all("rst_async");
    @(posedge clk);
    #1;
    cmp_all("rst_hold");
    rst_n = 1'b1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
  initial begin
    do_reset();
    idle("seq1"); check("seq1.v", pc, 32'h3004);
    idle("seq2"); check("seq2.v", pc, 32'h3008);
    idle("seq3"); check("seq3.v", pc, 32'h300C);
    do_reset();
    check("rst.epc", epc, 0);
    idle("s0"); idle("s1");
    drive("stall1", 1, 1, 32'h5000, 0, 0, 0, 0, 0, 0); check("stall1.v", pc, 32'h3008);
    drive("stall2", 1, 1, 32'h5000, 0, 0, 0, 0, 0, 0); check("stall2.v", pc, 32'h3008);
    drive("br", 0, 1, 32'h5000, 0, 0, 0, 0, 0, 0); check("br.v", pc, 32'h5000);
    drive("bralign", 0, 1, 32'h5003, 0, 0, 0, 0, 0, 0); check("bralign.v", pc, 32'h5000);
    do_reset();
    repeat (4) idle("e0");
    drive("exc1", 0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("exc1.pc", pc, EV); check("exc1.epc", epc, 32'h3010); check("exc1.h", {31'b0, in_h}, 1);
    idle("h1"); check("h1.v", pc, 32'h4184);
    drive("exc2", 0, 0, 0, 0, 0, 0, 0, 1, 0); check("exc2.epc", epc, 32'h3010);
    drive("eret", 0, 0, 0, 1, 32'h9000, 1, 0, 0, 1);
    check("eret.pc", pc, 32'h3010); check("eret.h", {31'b0, in_h}, 0);
    drive("eret_n", 0, 0, 0, 0, 0, 0, 0, 0, 1); check("eret_n.v", pc, 32'h3014);
    do_reset();
    drive("call1", 0, 0, 0, 1, 32'h6000, 1, 0, 0, 0);
    drive("call2", 0, 0, 0, 1, 32'h7000, 1, 0, 0, 0);
    drive("ret1", 0, 0, 0, 0, 0, 0, 1, 0, 0); check("ret1.v", pc, 32'h6004);
    drive("ret2", 0, 0, 0, 0, 0, 0, 1, 0, 0); check("ret2.v", pc, 32'h3004);
    check("ret2.empty", {31'b0, r_empty}, 1);
    for (int i = 0; i < 5; i++) drive("ovf", 0, 0, 0, 1, 32'h8000 + 32'(i) * 32'h100, 1, 0, 0, 0);
    check("ovf.full", {31'b0, r_full}, 1);
    for (int i = 0; i < 4; i++) begin
      drive("pop", 0, 0, 0, 0, 0, 0, 1, 0, 0);
      check("pop.v", pc, 32'h8304 - 32'(i) * 32'h100);
    end
    drive("uflow", 0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("uflow.pc", pc, 32'h8008); check("uflow.v", {31'b0, r_uf}, 1);
    idle("uflow_end"); check("uflow_end.v", {31'b0, r_uf}, 0);
    drive("rj", 0, 0, 0, 1, 32'hFFFF_FFFC, 1, 1, 0, 0);
    idle("wrap"); check("wrap.v", pc, 0);
    drive("prio", 1, 0, 0, 1, 32'h1234, 0, 0, 1, 0); check("prio.v", pc, EV);
    for (int r = 0; r < 4; r++) begin
      do_reset();
      repeat (100) drive("rand", $urandom_range(99) < 20, $urandom_range(99) < 15, $urandom,
                         $urandom_range(99) < 15, $urandom, $urandom_range(1), $urandom_range(99) < 25,
                         $urandom_range(99) < 5, $urandom_range(99) < 15);
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
